// File: rtl/alu_issue_ctrl.sv
// Registered issue front-end for the combinational 16-bit ALU with valid/ready request and response.
// Define ALU_MUL_EN to include the 16-cycle shift-add multiply built from repeated ALU Add operations.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_op1,
    input  logic [15:0] req_op2,
    input  logic [1:0]  req_op,
    input  logic        req_mul,
    output logic [15:0] alu_op1,
    output logic [15:0] alu_op2,
    output logic [1:0]  alu_operation,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_zero
);
    localparam logic [1:0] OP_ADD = 2'b10;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2, MUL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
`endif

    state_t state, state_nxt;
    logic   accept;
    logic   go_mul;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && (state == IDLE);

`ifdef ALU_MUL_EN
    logic [15:0] acc, mcand, mplier, acc_nxt;
    logic [3:0]  cnt;
    logic        mul_last;

    assign go_mul   = req_mul;
    assign acc_nxt  = mplier[0] ? alu_result : acc;
    assign mul_last = (cnt == 4'd15);

    // The ALU adds acc+mcand every iteration; the sum is kept only when the multiplier bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= 16'd0;
            mcand  <= 16'd0;
            mplier <= 16'd0;
            cnt    <= 4'd0;
        end else if (accept && go_mul) begin
            acc    <= 16'd0;
            mcand  <= req_op1;
            mplier <= req_op2;
            cnt    <= 4'd0;
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
        end
    end
`else
    logic mul_unused;

    assign go_mul     = 1'b0;
    assign mul_unused = req_mul;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef ALU_MUL_EN
                    state_nxt = go_mul ? MUL : EXEC;
`else
                    state_nxt = EXEC;
`endif
                end
            end
            EXEC: state_nxt = RESP;
`ifdef ALU_MUL_EN
            MUL: begin
                if (mul_last) begin
                    state_nxt = RESP;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU inputs are registered so they only move on clock edges; the response is held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op1       <= 16'd0;
            alu_op2       <= 16'd0;
            alu_operation <= 2'b00;
            rsp_result    <= 16'd0;
            rsp_zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (go_mul) begin
                            alu_op1       <= 16'd0;
                            alu_op2       <= req_op1;
                            alu_operation <= OP_ADD;
                        end else begin
                            alu_op1       <= req_op1;
                            alu_op2       <= req_op2;
                            alu_operation <= req_op;
                        end
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    alu_op1 <= acc_nxt;
                    alu_op2 <= mcand << 1;
                    if (mul_last) begin
                        rsp_result <= acc_nxt;
                        rsp_zero   <= (acc_nxt == 16'd0);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus randomized traffic against a transaction-level model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_mul;
    logic [15:0] req_op1, req_op2;
    logic [1:0]  req_op;
    logic [15:0] alu_op1, alu_op2, alu_result;
    logic [1:0]  alu_operation;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_zero;
    logic [15:0] rsp_result;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_op(req_op), .req_mul(req_mul),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    // Combinational ALU the block drives
    always_comb begin
        alu_result = 16'h0000;
        case (alu_operation)
            2'b00: alu_result = alu_op1 & alu_op2;
            2'b01: alu_result = alu_op1 | alu_op2;
            2'b10: alu_result = alu_op1 + alu_op2;
            default: alu_result = alu_op1 - alu_op2;
        endcase
        alu_zero = (alu_operation == 2'b11) && (alu_result == 16'h0000);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic mul);
        logic [31:0] p;
        logic [15:0] r;
        logic        z;
        if (mul) begin
            p = a * b;
            r = p[15:0];
            z = (r == 16'h0000);
        end else begin
            case (op)
                2'b00: r = a & b;
                2'b01: r = a | b;
                2'b10: r = a + b;
                default: r = a - b;
            endcase
            z = (op == 2'b11) && (r == 16'h0000);
        end
        return {z, r};
    endfunction

    function automatic logic [15:0] shl(input logic [15:0] a, input int k);
        logic [31:0] p;
        p = {16'h0000, a} << k;
        return p[15:0];
    endfunction

    function automatic logic [15:0] mul_part(input logic [15:0] a, input logic [15:0] b, input int k);
        logic [31:0] mask, p;
        mask = (32'd1 << k) - 32'd1;
        p = {16'h0000, a} * ({16'h0000, b} & mask);
        return p[15:0];
    endfunction

    // Transaction model: in flight for 1 (or 16 for multiply) cycles, then valid until taken
    logic        m_busy = 1'b0, m_valid = 1'b0, m_mul = 1'b0, m_zero = 1'b0;
    logic [15:0] m_a = 16'h0, m_b = 16'h0, m_res = 16'h0;
    logic [1:0]  m_op = 2'b00;
    int          m_wait = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_mul   <= 1'b0;
            m_wait  <= 0;
        end else if (m_valid) begin
            if (rsp_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_wait == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
            end
            m_wait <= m_wait - 1;
        end else if (req_valid) begin
            m_busy           <= 1'b1;
            m_mul            <= MUL_EN & req_mul;
            m_wait           <= (MUL_EN & req_mul) ? 16 : 1;
            m_a              <= req_op1;
            m_b              <= req_op2;
            m_op             <= req_op;
            {m_zero, m_res}  <= ref_op(req_op, req_op1, req_op2, MUL_EN & req_mul);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", req_ready, !m_busy && !m_valid);
            chk("rsp_valid", rsp_valid, m_valid);
            if (m_valid) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_zero", rsp_zero, m_zero);
            end
            if (m_busy && !m_mul) begin
                chk("exec_op1", alu_op1, m_a);
                chk("exec_op2", alu_op2, m_b);
                chk("exec_operation", alu_operation, m_op);
            end
            if (m_busy && m_mul) begin
                chk("mul_operation", alu_operation, 2'b10);
                chk("mul_op2", alu_op2, shl(m_a, 16 - m_wait));
                chk("mul_op1", alu_op1, mul_part(m_a, m_b, 16 - m_wait));
            end
        end
    end

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic mul, input logic [15:0] er, input logic ez,
                          input int lat, input string nm);
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_op1 = a; req_op2 = b; req_mul = mul;
        @(negedge clk);
        req_valid = 1'b0; req_mul = 1'b0;
        wait_rsp(cyc);
        chk({nm, "_latency"}, cyc, lat);
        chk({nm, "_result"}, rsp_result, er);
        chk({nm, "_zero"}, rsp_zero, ez);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b0; req_valid = 1'b0; req_op1 = 16'h0; req_op2 = 16'h0;
        req_op = 2'b00; req_mul = 1'b0; rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_result", rsp_result, 16'h0000);
        chk("reset_rsp_zero", rsp_zero, 1'b0);
        chk("reset_alu_op1", alu_op1, 16'h0000);
        chk("reset_alu_op2", alu_op2, 16'h0000);
        chk("reset_alu_operation", alu_operation, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(2'b11, 16'd5, 16'd5, 1'b0, 16'h0000, 1'b1, 1, "sub_eq");
        run_op(2'b11, 16'd7, 16'd5, 1'b0, 16'h0002, 1'b0, 1, "sub_ne");
        run_op(2'b10, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1, "add_wrap");
        run_op(2'b00, 16'hF0F0, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 1, "and_zero");
`ifdef ALU_MUL_EN
        run_op(2'b00, 16'd300, 16'd300, 1'b1, 16'h5F90, 1'b0, 16, "mul_300");
        run_op(2'b00, 16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b1, 16, "mul_zero");
`else
        run_op(2'b10, 16'd300, 16'd300, 1'b1, 16'h0258, 1'b0, 1, "mul_ignored");
`endif

        // Backpressure with a competing request held on the input
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_op1 = 16'h1200; req_op2 = 16'h0034; req_mul = 1'b0;
        @(negedge clk);
        req_op = 2'b00; req_op1 = 16'hFFFF; req_op2 = 16'h00FF;
        wait_rsp(cyc);
        chk("bp_latency", cyc, 1);
        repeat (5) begin
            chk("bp_result", rsp_result, 16'h1234);
            chk("bp_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_idle_ready", req_ready, 1'b1);
        chk("bp_idle_valid", rsp_valid, 1'b0);
        @(negedge clk);
        chk("bp_taken", req_ready, 1'b0);
        req_valid = 1'b0;
        wait_rsp(cyc);
        chk("bp2_latency", cyc, 1);
        chk("bp2_result", rsp_result, 16'h00FF);
        chk("bp2_zero", rsp_zero, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while an operation is in flight
        @(negedge clk);
`ifdef ALU_MUL_EN
        req_valid = 1'b1; req_mul = 1'b1; req_op1 = 16'd123; req_op2 = 16'd456;
        @(negedge clk);
        req_valid = 1'b0; req_mul = 1'b0;
        repeat (7) @(negedge clk);
`else
        req_valid = 1'b1; req_op = 2'b10; req_op1 = 16'd3; req_op2 = 16'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
`endif
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_alu_op1", alu_op1, 16'h0000);
        chk("rst_alu_op2", alu_op2, 16'h0000);
        chk("rst_alu_operation", alu_operation, 2'b00);
        chk("rst_rsp_result", rsp_result, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", req_ready, 1'b1);
        run_op(2'b00, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 1'b0, 1, "and_after_rst");

        // Randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 2) != 0);
            req_op    = 2'($urandom_range(0, 3));
            req_op1   = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            req_op2   = ($urandom_range(0, 3) == 0) ? req_op1 : 16'($urandom);
            req_mul   = ($urandom_range(0, 4) == 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
